q_change_logger: RTL and testbench

Q_CHANGE_LOGGER -- requirements
Module: q_change_logger

---
 rtl/q_change_logger.sv | 197 +++++++++++++++++++
 tb/tb_q_change_logger.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_change_logger.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// q_change_logger
//
// Watches a WIDTH-bit value and records each change as an event
// {timestamp, old value, new value} in a DEPTH-entry show-ahead FIFO.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   enable         arms change monitoring and runs the timestamp counter
//   sample         monitored value, synchronous to clock
//   evt_valid      FIFO head holds an event
//   evt_ready      consumer pop request
//   evt_time       head timestamp            (0 while evt_valid=0)
//   evt_old        head value before change  (0 while evt_valid=0)
//   evt_new        head value after change   (0 while evt_valid=0)
//   count          FIFO occupancy, 0..DEPTH
//   overflow       sticky: an event was dropped because the FIFO was full
//   dropped        saturating count of dropped events
//   clear_overflow zeroes overflow and dropped on the next edge
//
// Handshake: an event transfers on the rising edge where evt_valid=1 and
// evt_ready=1. evt_valid never depends on evt_ready, the head fields stay
// stable until that edge, and evt_ready while evt_valid=0 is ignored.
//
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// -----------------------------------------------------------------------------
module q_change_logger #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 12
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          sample,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [TS_WIDTH-1:0]       evt_time,
    output logic [WIDTH-1:0]          evt_old,
    output logic [WIDTH-1:0]          evt_new,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [7:0]                dropped,
    input  logic                      clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_WIDTH + 2 * WIDTH;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TS_WIDTH-1:0] timer;
    logic [WIDTH-1:0]    prev;
    logic                armed;

    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count_q;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic          change;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;
    logic [EW-1:0] new_entry;
    logic [EW-1:0] head;

    always_comb begin
        // A change only counts once armed, so the arming cycle (and any
        // change that happened while disabled) never produces an event.
        change    = enable && armed && (sample != prev);
        new_entry = {timer, prev, sample};

        evt_valid = (count_q != '0);
        pop       = evt_valid && evt_ready;
        full      = (count_q == FULL_COUNT);

        // A pop in the same cycle frees the slot the push needs.
        push      = change && (!full || pop);
        drop      = change && full && !pop;
    end

    // ------------------------------------------------------------------
    // Timestamp counter: free-running while enabled, parked at 0 otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (enable) begin
            timer <= timer + TS_WIDTH'(1);
        end else begin
            timer <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Change detector
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev  <= '0;
            armed <= 1'b0;
        end else if (!enable) begin
            armed <= 1'b0;
        end else if (!armed) begin
            // First enabled cycle: capture a reference, report nothing.
            prev  <= sample;
            armed <= 1'b1;
        end else if (change) begin
            // prev follows sample even when the event is dropped, so a
            // full FIFO never causes a stale change to be reported later.
            prev <= sample;
        end
    end

    // ------------------------------------------------------------------
    // Event storage (data only; validity is carried by count_q)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Overflow bookkeeping. A drop in the same cycle as clear_overflow
    // wins: the clear wipes the history and the new drop is counted
    // as the first one.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            dropped  <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                dropped <= 8'd1;
            end else if (dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end
        end else if (clear_overflow) begin
            overflow <= 1'b0;
            dropped  <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead head outputs. The storage is not reset, so the fields
    // are forced to zero whenever there is no valid head.
    // ------------------------------------------------------------------
    always_comb begin
        head     = mem[rd_ptr];
        evt_time = '0;
        evt_old  = '0;
        evt_new  = '0;
        if (evt_valid) begin
            evt_time = head[EW-1 -: TS_WIDTH];
            evt_old  = head[2*WIDTH-1 -: WIDTH];
            evt_new  = head[WIDTH-1:0];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_q_change_logger.sv
`timescale 1ns/1ps
module tb_q_change_logger;

  localparam int W     = 4;
  localparam int D     = 8;
  localparam int TS    = 12;
  localparam int EW    = TS + 2 * W;

  // ---------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------
  logic          clock;
  logic          reset_n;
  logic          enable;
  logic [W-1:0]  sample;
  logic          evt_valid;
  logic          evt_ready;
  logic [TS-1:0] evt_time;
  logic [W-1:0]  evt_old;
  logic [W-1:0]  evt_new;
  logic [3:0]    count;
  logic          overflow;
  logic [7:0]    dropped;
  logic          clear_overflow;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  q_change_logger #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TS)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .sample         (sample),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_time       (evt_time),
    .evt_old        (evt_old),
    .evt_new        (evt_new),
    .count          (count),
    .overflow       (overflow),
    .dropped        (dropped),
    .clear_overflow (clear_overflow)
  );

  // ---------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  logic [TS-1:0] m_timer;
  logic [W-1:0]  m_prev;
  logic          m_armed;
  logic          m_ovf;
  logic [7:0]    m_drop;
  int            n_vec;
  int            n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string name, input logic [TS-1:0] t, input logic [W-1:0] o,
                          input logic [W-1:0] n);
    chk(name, {11'd0, evt_valid, evt_time, evt_old, evt_new}, {11'd0, 1'b1, t, o, n});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_timer = '0;
    m_prev  = '0;
    m_armed = 1'b0;
    m_ovf   = 1'b0;
    m_drop  = '0;
  endtask

  // ---------------------------------------------------------------
  // Driver: one clock cycle. Called at posedge+1, returns at posedge+1.
  // ---------------------------------------------------------------
  task automatic step(input logic en, input logic [W-1:0] smp, input logic rdy, input logic clr);
    logic          m_pop;
    logic          drop;
    logic [EW-1:0] e;
    enable         = en;
    sample         = smp;
    evt_ready      = rdy;
    clear_overflow = clr;
    #1;
    chk("count", {28'd0, count}, exp_q.size());
    chk("valid", {31'd0, evt_valid}, {31'd0, exp_q.size() != 0});
    m_pop = (exp_q.size() != 0) && rdy;
    if (m_pop) begin
      e = exp_q.pop_front();
      chk("pop_time", {20'd0, evt_time}, {20'd0, e[EW-1 -: TS]});
      chk("pop_old",  {28'd0, evt_old},  {28'd0, e[2*W-1 -: W]});
      chk("pop_new",  {28'd0, evt_new},  {28'd0, e[W-1:0]});
    end else if (exp_q.size() == 0) begin
      chk("idle_zero", {12'd0, evt_time, evt_old, evt_new}, 32'd0);
    end
    drop = 1'b0;
    if (!en) begin
      m_armed = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
      m_prev  = smp;
    end else if (smp != m_prev) begin
      if (exp_q.size() < D) exp_q.push_back({m_timer, m_prev, smp});
      else drop = 1'b1;
      m_prev = smp;
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    m_timer = en ? m_timer + 12'd1 : 12'd0;
    @(posedge clock);
    #1;
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("dropped",  {24'd0, dropped},  {24'd0, m_drop});
  endtask

  // ---------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------
  typedef struct {
    logic          en;
    logic [W-1:0]  smp;
    logic          rdy;
    logic          clr;
    logic          hchk;
    logic [TS-1:0] h_time;
    logic [W-1:0]  h_old;
    logic [W-1:0]  h_new;
    int            exp_cnt;
    logic          exp_ovf;
    int            exp_drp;
  } vec_t;

  vec_t vecs[39];

  function automatic vec_t mk(input logic en, input logic [W-1:0] smp, input logic rdy,
                              input logic clr, input int cnt, input logic ovf, input int drp);
    vec_t v;
    v.en = en; v.smp = smp; v.rdy = rdy; v.clr = clr;
    v.hchk = 1'b0; v.h_time = '0; v.h_old = '0; v.h_new = '0;
    v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_drp = drp;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();

    // Overflow/full/clear/disable-drain table; timer is 0 at row 0.
    vecs[0] = mk(1'b1, 4'h0, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int k = 1; k <= 10; k++)
      vecs[k] = mk(1'b1, ((k % 2) != 0) ? 4'h1 : 4'h0, 1'b0, 1'b0,
                   (k < D) ? k : D, k > D, (k > D) ? k - D : 0);
    vecs[11] = mk(1'b1, 4'h1, 1'b1, 1'b0, 8, 1'b1, 2);
    vecs[11].hchk = 1'b1; vecs[11].h_time = 12'd1; vecs[11].h_old = 4'h0; vecs[11].h_new = 4'h1;
    for (int k = 12; k <= 19; k++)
      vecs[k] = mk(1'b1, 4'h1, 1'b1, 1'b0, 19 - k, 1'b1, 2);
    vecs[19].hchk = 1'b1; vecs[19].h_time = 12'd11; vecs[19].h_old = 4'h0; vecs[19].h_new = 4'h1;
    vecs[20] = mk(1'b1, 4'h1, 1'b0, 1'b1, 0, 1'b0, 0);
    for (int k = 21; k <= 28; k++)
      vecs[k] = mk(1'b1, ((k % 2) != 0) ? 4'h0 : 4'h1, 1'b0, 1'b0, k - 20, 1'b0, 0);
    vecs[29] = mk(1'b1, 4'h0, 1'b0, 1'b1, 8, 1'b1, 1);
    vecs[30] = mk(1'b1, 4'h0, 1'b0, 1'b1, 8, 1'b0, 0);
    for (int k = 31; k <= 38; k++)
      vecs[k] = mk(1'b0, 4'h5, 1'b1, 1'b0, 38 - k, 1'b0, 0);
    vecs[31].hchk = 1'b1; vecs[31].h_time = 12'd21; vecs[31].h_old = 4'h1; vecs[31].h_new = 4'h0;

    // Reset
    reset_n = 1'b0; enable = 1'b0; sample = '0; evt_ready = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outputs", {evt_valid, evt_time, evt_old, evt_new, count, overflow, dropped}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_outputs", {evt_valid, evt_time, evt_old, evt_new, count, overflow, dropped}, 32'd0);
    @(posedge clock);
    #1;

    // Basic detection: events {5,0,1} and {15,1,F}
    for (int t = 0; t <= 20; t++) begin
      if (t == 6)  chk_head("d34_ev1", 12'd5, 4'h0, 4'h1);
      if (t == 16) chk_head("d34_ev2", 12'd15, 4'h1, 4'hF);
      step(1'b1, (t < 5) ? 4'h0 : ((t < 15) ? 4'h1 : 4'hF), 1'b1, 1'b0);
    end
    step(1'b0, 4'hF, 1'b1, 1'b0);

    // Table
    for (int i = 0; i < 39; i++) begin
      if (vecs[i].hchk)
        chk_head($sformatf("tbl%0d_head", i), vecs[i].h_time, vecs[i].h_old, vecs[i].h_new);
      step(vecs[i].en, vecs[i].smp, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("tbl%0d_count", i), {28'd0, count}, vecs[i].exp_cnt);
      chk($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("tbl%0d_drp", i), {24'd0, dropped}, vecs[i].exp_drp);
    end

    // Timer wrap: changes at FFF and 000
    for (int i = 0; i < 4095; i++) step(1'b1, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h1, 1'b1, 1'b0);
    chk_head("wrap_fff", 12'hFFF, 4'h0, 4'h1);
    step(1'b1, 4'h2, 1'b1, 1'b0);
    chk_head("wrap_000", 12'h000, 4'h1, 4'h2);
    step(1'b1, 4'h2, 1'b1, 1'b0);

    // Change while disabled is not reported
    step(1'b0, 4'h3, 1'b1, 1'b0);
    step(1'b0, 4'h3, 1'b1, 1'b0);
    step(1'b0, 4'h7, 1'b1, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    chk("d38_noevt", {28'd0, count}, 32'd0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    chk_head("d38_ev", 12'd2, 4'h7, 4'h2);
    step(1'b1, 4'h2, 1'b1, 1'b0);

    // Reset with three queued events
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    chk("d39_queued", {28'd0, count}, 32'd3);
    reset_n = 1'b0;
    enable  = 1'b1;
    sample  = 4'h9;
    #1;
    chk("d39_async", {11'd0, evt_valid, evt_time, evt_old, evt_new, count}, 32'd0);
    @(posedge clock);
    #1;
    chk("d39_flags", {23'd0, overflow, dropped}, 32'd0);
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 4'h5, 1'b1, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    chk("d39_noevt", {28'd0, count}, 32'd0);
    step(1'b1, 4'h6, 1'b1, 1'b0);
    step(1'b1, 4'h6, 1'b1, 1'b0);

    // Dropped counter saturation
    for (int i = 0; i < 270; i++)
      step(1'b1, ((i % 2) == 0) ? 4'hA : 4'h5, 1'b0, 1'b0);
    chk("sat_dropped", {24'd0, dropped}, 32'd255);
    chk("sat_count", {28'd0, count}, 32'd8);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    chk("sat_clear", {23'd0, overflow, dropped}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
